store_drain: RTL and testbench

STORE_DRAIN -- requirements
Module: store_drain

---
 rtl/store_drain.sv | 192 +++++++++++++++++++
 tb/tb_store_drain.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_drain.sv
// ---------------------------------------------------------------------------
// store_drain
//
// Committed-store buffer that drains into the data cache one write at a time.
// Stores arrive from commit, are held in a circular FIFO and are written to
// the cache through a request / address-accept / data-complete handshake with
// at most one request outstanding. Entries are only removed when the cache
// reports the write complete, so they survive pipeline flushes.
//
// Optional feature (macro STORE_DRAIN_FWD_EN): combinational store-to-load
// forwarding from every held entry, newest entry winning per byte lane.
// Without the macro the forwarding outputs are tied to zero.
//
// Ports
//   clk_g, reset                  clock, synchronous active-high reset
//   commit_valid/addr/wdata/we    committed store in; commit_ready = free slot
//   data_req/wr/wstrb/addr/wdata  cache write request (head entry)
//   data_addr_ok, data_data_ok    cache accept / write-complete
//   ld_valid, ld_addr             load lookup
//   ld_fwd_be, ld_fwd_data        forwarded lanes and bytes
//   drain_empty                   nothing held and nothing in flight
// ---------------------------------------------------------------------------
module store_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8
) (
  input  logic                  clk_g,
  input  logic                  reset,
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] commit_addr,
  input  logic [DATA_WIDTH-1:0] commit_wdata,
  input  logic [3:0]            commit_we,
  output logic                  commit_ready,
  output logic                  data_req,
  output logic                  data_wr,
  output logic [3:0]            data_wstrb,
  output logic [DATA_WIDTH-1:0] data_addr,
  output logic [DATA_WIDTH-1:0] data_wdata,
  input  logic                  data_addr_ok,
  input  logic                  data_data_ok,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_addr,
  output logic [3:0]            ld_fwd_be,
  output logic [DATA_WIDTH-1:0] ld_fwd_data,
  output logic                  drain_empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [DEPTH-1:0]       valid_q, valid_d;

  // Entry payload carries no reset; the valid bits qualify it.
  logic [DATA_WIDTH-1:0]  addr_mem_q  [DEPTH];
  logic [DATA_WIDTH-1:0]  wdata_mem_q [DEPTH];
  logic [3:0]             we_mem_q    [DEPTH];

  logic                   push;
  logic                   pop;

  // Readiness looks only at the registered count, never at a same-cycle pop.
  assign commit_ready = (count_q != FULL_CNT);
  // A store with no enabled lanes is accepted on the bus but never queued.
  assign push         = commit_valid && commit_ready && (commit_we != 4'b0000);

  // Drain FSM: one request in flight at a time.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    data_req = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A push into an empty buffer lands at the head, so the request can
        // start in the very next cycle.
        if ((count_q != '0) || push) state_d = ST_REQ;
      end
      ST_REQ: begin
        data_req = 1'b1;
        if (data_addr_ok && data_data_ok) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end else if (data_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (data_data_ok) begin
          pop     = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FIFO bookkeeping
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (pop) begin
      head_d          = head_q + PTR_W'(1);
      valid_d[head_q] = 1'b0;
    end
    if (push) begin
      tail_d          = tail_q + PTR_W'(1);
      valid_d[tail_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_g) begin
    if (reset) begin
      state_q <= ST_IDLE;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_g) begin
    if (push) begin
      addr_mem_q[tail_q]  <= commit_addr;
      wdata_mem_q[tail_q] <= commit_wdata;
      we_mem_q[tail_q]    <= commit_we;
    end
  end

  // The head entry is stable from request start until its pop because the
  // head pointer only moves on a pop.
  assign data_wr     = 1'b1;
  assign data_addr   = addr_mem_q[head_q];
  assign data_wdata  = wdata_mem_q[head_q];
  assign data_wstrb  = valid_q[head_q] ? we_mem_q[head_q] : 4'b0000;
  assign drain_empty = (count_q == '0) && (state_q == ST_IDLE);

`ifdef STORE_DRAIN_FWD_EN
  logic [PTR_W-1:0] fwd_idx;
  logic             unused_ld_lo;

  assign unused_ld_lo = ^ld_addr[1:0];

  // Walk entries oldest to newest so a newer match overwrites older lanes.
  always_comb begin
    ld_fwd_be   = 4'b0000;
    ld_fwd_data = '0;
    fwd_idx     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if (ld_valid && valid_q[fwd_idx] &&
          (addr_mem_q[fwd_idx][DATA_WIDTH-1:2] == ld_addr[DATA_WIDTH-1:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (we_mem_q[fwd_idx][b]) begin
            ld_fwd_be[b]         = 1'b1;
            ld_fwd_data[8*b +: 8] = wdata_mem_q[fwd_idx][8*b +: 8];
          end
        end
      end
    end
  end
`else
  logic unused_ld;

  assign unused_ld   = ^{ld_valid, ld_addr};
  assign ld_fwd_be   = 4'b0000;
  assign ld_fwd_data = '0;
`endif

endmodule

// File: tb/tb_store_drain.sv
module tb_store_drain;

  localparam int DEPTH = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  we;
  } st_t;

  logic        clk_g = 1'b0;
  logic        reset;
  logic        commit_valid;
  logic [31:0] commit_addr;
  logic [31:0] commit_wdata;
  logic [3:0]  commit_we;
  logic        commit_ready;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [3:0]  ld_fwd_be;
  logic [31:0] ld_fwd_data;
  logic        drain_empty;

  store_drain #(.DATA_WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk_g        (clk_g),
    .reset        (reset),
    .commit_valid (commit_valid),
    .commit_addr  (commit_addr),
    .commit_wdata (commit_wdata),
    .commit_we    (commit_we),
    .commit_ready (commit_ready),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_fwd_be    (ld_fwd_be),
    .ld_fwd_data  (ld_fwd_data),
    .drain_empty  (drain_empty)
  );

  always #5 clk_g = ~clk_g;

  // Reference model: queue of held stores (oldest first) plus an
  // "accepted but not completed" flag for the cache side.
  st_t q[$];
  bit  outstanding;
  int  pops;
  int  vectors;
  int  miscmp;
  bit  auto_cm;
  bit  auto_hs;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscmp++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0000_1000 + 32'($urandom_range(0, 3) << 2) + 32'($urandom_range(0, 3));
  endfunction

  task automatic idle_inputs();
    commit_valid = 1'b0;
    commit_addr  = '0;
    commit_wdata = '0;
    commit_we    = 4'b0000;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    ld_valid     = 1'b0;
    ld_addr      = '0;
  endtask

  task automatic set_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    commit_valid = 1'b1;
    commit_addr  = a;
    commit_wdata = d;
    commit_we    = we;
  endtask

  // One clock cycle: optional random stimulus, model checks, model update.
  task automatic tick();
    logic [3:0]  exp_be;
    logic [31:0] exp_d;
    logic [31:0] mask;
    bit          rdy_m;
    bit          acc;
    st_t         e;
    if (auto_cm) begin
      commit_valid = 1'($urandom_range(0, 1));
      commit_addr  = rand_addr();
      commit_wdata = $urandom();
      commit_we    = 4'($urandom_range(0, 15));
      ld_valid     = 1'($urandom_range(0, 1));
      ld_addr      = rand_addr();
    end
    if (auto_hs) begin
      if (outstanding) begin
        data_addr_ok = 1'b0;
        data_data_ok = ($urandom_range(0, 2) == 0);
      end else if (data_req) begin
        data_addr_ok = ($urandom_range(0, 2) == 0);
        data_data_ok = data_addr_ok ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 4) == 0);
      end else begin
        data_addr_ok = 1'b0;
        data_data_ok = ($urandom_range(0, 5) == 0);
      end
    end
    #1;
    if (reset) begin
      q.delete();
      outstanding = 1'b0;
    end else begin
      rdy_m = (q.size() != DEPTH);
      check("commit_ready", commit_ready, rdy_m);
      check("drain_empty", drain_empty, (q.size() == 0));
      check("data_wr", data_wr, 1);
      check("req_legal", data_req && (q.size() == 0 || outstanding), 0);
      if ((data_req || outstanding) && q.size() > 0) begin
        check("head_addr", data_addr, q[0].addr);
        check("head_wdata", data_wdata, q[0].data);
        check("head_wstrb", data_wstrb, q[0].we);
      end
      exp_be = 4'b0000;
      exp_d  = '0;
`ifdef STORE_DRAIN_FWD_EN
      foreach (q[i]) begin
        if (ld_valid && (q[i].addr[31:2] == ld_addr[31:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (q[i].we[b]) begin
              exp_be[b]       = 1'b1;
              exp_d[8*b +: 8] = q[i].data[8*b +: 8];
            end
          end
        end
      end
      mask = {{8{exp_be[3]}}, {8{exp_be[2]}}, {8{exp_be[1]}}, {8{exp_be[0]}}};
`else
      mask = 32'hFFFF_FFFF;
`endif
      check("fwd_be", ld_fwd_be, exp_be);
      check("fwd_data", ld_fwd_data & mask, exp_d);
      acc = data_req && data_addr_ok;
      if (data_data_ok && (outstanding || acc) && q.size() > 0) begin
        e = q.pop_front();
        pops++;
        outstanding = 1'b0;
      end else if (acc) begin
        outstanding = 1'b1;
      end
      if (commit_valid && rdy_m && commit_we != 4'b0000) begin
        e.addr = commit_addr;
        e.data = commit_wdata;
        e.we   = commit_we;
        q.push_back(e);
      end
    end
    @(posedge clk_g);
    #1;
  endtask

  task automatic drain();
    auto_cm = 1'b0;
    auto_hs = 1'b1;
    idle_inputs();
    for (int k = 0; k < 500 && (q.size() != 0 || outstanding); k++) tick();
    check("drain_model_empty", q.size(), 0);
    auto_hs = 1'b0;
    idle_inputs();
    tick();
    check("drain_empty_final", drain_empty, 1);
  endtask

  initial begin
    int p0;
    vectors = 0;
    miscmp  = 0;
    pops    = 0;
    auto_cm = 1'b0;
    auto_hs = 1'b0;
    outstanding = 1'b0;
    idle_inputs();
    reset = 1'b1;
    @(posedge clk_g);
    #1;
    tick();
    tick();
    reset = 1'b0;

    // Reset values, with a live lookup to make the forwarding check meaningful
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_1000;
    #1;
    check("rst_data_req", data_req, 0);
    check("rst_wstrb", data_wstrb, 0);
    check("rst_commit_ready", commit_ready, 1);
    check("rst_drain_empty", drain_empty, 1);
    check("rst_fwd_be", ld_fwd_be, 0);
    check("rst_fwd_data", ld_fwd_data, 0);
    idle_inputs();
    tick();

    // Single store with addr_ok at +2 and data_ok at +4
    set_store(32'h8000_1000, 32'hDEAD_BEEF, 4'hF);
    check("s1_req_c0", data_req, 0);
    tick();
    idle_inputs();
    check("s1_req_c1", data_req, 1);
    tick();
    data_addr_ok = 1'b1;
    check("s1_req_c2", data_req, 1);
    check("s1_addr", data_addr, 32'h8000_1000);
    check("s1_wdata", data_wdata, 32'hDEAD_BEEF);
    check("s1_wstrb", data_wstrb, 4'hF);
    tick();
    data_addr_ok = 1'b0;
    check("s1_req_c3", data_req, 0);
    check("s1_busy_c3", drain_empty, 0);
    tick();
    data_data_ok = 1'b1;
    check("s1_busy_c4", drain_empty, 0);
    tick();
    data_data_ok = 1'b0;
    check("s1_empty_c5", drain_empty, 1);
    check("s1_req_c5", data_req, 0);
    tick();

    // Dropped store: no lanes enabled
    set_store(32'h0000_2000, 32'h1234_5678, 4'h0);
    tick();
    idle_inputs();
    check("drop_empty", drain_empty, 1);
    tick();

    // Fill to full with the cache stalled
    for (int i = 0; i < 8; i++) begin
      set_store(32'h0000_3000 + 32'(i * 4), 32'hA000_0000 + 32'(i), 4'hF);
      tick();
    end
    idle_inputs();
    check("full_ready", commit_ready, 0);
    set_store(32'h0000_3FF0, 32'hBAD0_BAD0, 4'hF);
    tick();
    idle_inputs();
    check("full_ready_9th", commit_ready, 0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    check("full_slot_freed", commit_ready, 1);
    drain();

    // Forwarding: sb 0x11 @0x100 then sh 0x2233 @0x102, lookup 0x100
    set_store(32'h0000_0100, 32'h0000_0011, 4'b0001);
    tick();
    set_store(32'h0000_0102, 32'h2233_0000, 4'b1100);
    tick();
    idle_inputs();
    ld_valid = 1'b1;
    ld_addr  = 32'h0000_0100;
    #1;
`ifdef STORE_DRAIN_FWD_EN
    check("fwd_dir_be", ld_fwd_be, 4'hD);
    check("fwd_dir_data", ld_fwd_data & 32'hFFFF_00FF, 32'h2233_0011);
`else
    check("fwd_off_be", ld_fwd_be, 4'h0);
    check("fwd_off_data", ld_fwd_data, 32'h0);
`endif
    tick();
    drain();

    // Reset while waiting for completion, then a stray data_ok
    set_store(32'h0000_4000, 32'h5555_AAAA, 4'hF);
    tick();
    idle_inputs();
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    check("rw_busy", drain_empty, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    data_data_ok = 1'b1;
    check("rw_req", data_req, 0);
    check("rw_empty", drain_empty, 1);
    check("rw_wstrb", data_wstrb, 0);
    check("rw_ready", commit_ready, 1);
    tick();
    data_data_ok = 1'b0;
    check("rw_req_after", data_req, 0);
    check("rw_empty_after", drain_empty, 1);
    tick();

    // Same-cycle addr_ok/data_ok with count=1 and a simultaneous push
    set_store(32'h0000_5000, 32'h0101_0101, 4'hF);
    tick();
    set_store(32'h0000_6004, 32'h0202_0202, 4'h3);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    check("sc_req", data_req, 1);
    tick();
    idle_inputs();
    check("sc_busy", drain_empty, 0);
    check("sc_req_gap", data_req, 0);
    tick();
    check("sc_req_new", data_req, 1);
    check("sc_addr_new", data_addr, 32'h0000_6004);
    check("sc_wdata_new", data_wdata, 32'h0202_0202);
    check("sc_wstrb_new", data_wstrb, 4'h3);
    data_addr_ok = 1'b1;
    data_data_ok = 1'b1;
    tick();
    idle_inputs();
    check("sc_count_was_1", drain_empty, 1);
    tick();

    // Randomized traffic with wrap-around: at least 20 stores drained
    auto_cm = 1'b1;
    auto_hs = 1'b1;
    p0 = pops;
    for (int k = 0; k < 3000 && (pops - p0) < 20; k++) tick();
    check("rand_pops_20", ((pops - p0) >= 20), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule
